clk_div_ctrl: RTL and testbench

- Single-clock programmable integer clock-divider controller. It generates a divided clock-enable waveform (clk_out) with a runtime-selectable divisor from 2 to 2^DIV_W-1.
- Divisor changes are sequenced glitch-free: a new ratio is applied only at a period boundary, and the update is acknowledged with a pulse.
- Start and stop are graceful: stopping always completes the current period. The block sits in front of the divide-by-N datapaths and replaces fixed dividers with one managed source.

---
 rtl/clk_div_ctrl.sv | 135 +++++++++++++
 tb/tb_clk_div_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : clk_div_ctrl                                                     |
// | Brief  : Programmable integer clock-enable divider. The divisor changes   |
// |          only at period boundaries. Start and stop are graceful.          |
// |          Optional macro CLKDIV_TICK_EN adds rise_tick / period_cnt.       |
// | Rev    : 1.0                                                             |
// +--------------------------------------------------------------------------+
module clk_div_ctrl #(
  parameter int DIV_W       = 4,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             div_req,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             div_busy,
  output logic [DIV_W-1:0] active_div,
  output logic [DIV_W-1:0] cnt,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             rise_tick,
  output logic [15:0]      period_cnt
`endif
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_STOP = 2'd2;

  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic             r_clk_out;
  logic [DIV_W-1:0] r_active_div;
  logic [DIV_W-1:0] r_pend_div;
  logic             r_busy;
  logic             r_ack;
  logic             r_err;

  logic             w_running;
  logic             w_wrap;
  logic             w_apply;
  logic             w_bad;
  logic             w_take;
  logic [1:0]       w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DIV_W:0]   w_half_nxt;
  logic             w_high_nxt;

  assign w_running = (r_state != c_ST_IDLE);
  assign w_wrap    = w_running && (r_cnt == (r_active_div - DIV_W'(1)));

  // A pending divisor is applied at a wrap, or on the next edge while idle.
  assign w_apply   = r_busy && (!w_running || w_wrap);
  assign w_bad     = div_req && (div_val < DIV_W'(2));
  assign w_take    = div_req && !w_bad && !r_busy;
  assign w_div_nxt = w_apply ? r_pend_div : r_active_div;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (en) w_state_nxt = c_ST_RUN;
      c_ST_RUN:  if (!en) w_state_nxt = c_ST_STOP;
      c_ST_STOP: begin
        if (en)          w_state_nxt = c_ST_RUN;
        else if (w_wrap) w_state_nxt = c_ST_IDLE;
      end
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  assign w_cnt_nxt  = (w_running && !w_wrap) ? (r_cnt + DIV_W'(1)) : '0;

  // High time is ceil(N/2); one extra bit keeps N = 2^DIV_W-1 from overflowing.
  assign w_half_nxt = ({1'b0, w_div_nxt} + (DIV_W+1)'(1)) >> 1;
  assign w_high_nxt = (w_state_nxt != c_ST_IDLE) && ({1'b0, w_cnt_nxt} < w_half_nxt);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= c_ST_IDLE;
      r_cnt        <= '0;
      r_clk_out    <= 1'b0;
      r_active_div <= DIV_W'(DEFAULT_DIV);
      r_pend_div   <= '0;
      r_busy       <= 1'b0;
      r_ack        <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_clk_out    <= w_high_nxt;
      r_active_div <= w_div_nxt;
      r_ack        <= w_apply;
      r_err        <= w_bad;
      if (w_take) begin
        r_pend_div <= div_val;
        r_busy     <= 1'b1;
      end else if (w_apply) begin
        r_busy     <= 1'b0;
      end
    end
  end

  assign div_ack    = r_ack;
  assign div_err    = r_err;
  assign div_busy   = r_busy;
  assign active_div = r_active_div;
  assign cnt        = r_cnt;
  assign clk_out    = r_clk_out;

`ifdef CLKDIV_TICK_EN
  logic        r_rise_tick;
  logic [15:0] r_period_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rise_tick  <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_rise_tick <= (w_state_nxt != c_ST_IDLE) && (w_cnt_nxt == '0);
      if (w_wrap) r_period_cnt <= r_period_cnt + 16'd1;
    end
  end

  assign rise_tick  = r_rise_tick;
  assign period_cnt = r_period_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// Bench for clk_div_ctrl: period-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clk_div_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       div_req;
  logic [3:0] div_val;
  logic       div_ack;
  logic       div_err;
  logic       div_busy;
  logic [3:0] active_div;
  logic [3:0] cnt;
  logic       clk_out;
`ifdef CLKDIV_TICK_EN
  logic        rise_tick;
  logic [15:0] period_cnt;
`endif

  clk_div_ctrl #(.DIV_W(4), .DEFAULT_DIV(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .div_req    (div_req),
    .div_val    (div_val),
    .div_ack    (div_ack),
    .div_err    (div_err),
    .div_busy   (div_busy),
    .active_div (active_div),
    .cnt        (cnt),
    .clk_out    (clk_out)
`ifdef CLKDIV_TICK_EN
    ,
    .rise_tick  (rise_tick),
    .period_cnt (period_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 stopping; phase within period.
  int m_mode = 0, m_phase = 0, m_div = 3, m_pend = 0, m_pcnt = 0;
  bit m_ack = 0, m_err = 0, m_out = 0, m_tick = 0;

  task automatic model_step();
    int old_mode, old_pend;
    bit wrap;
    old_mode = m_mode;
    old_pend = m_pend;
    if (!reset) begin
      m_mode = 0; m_phase = 0; m_div = 3; m_pend = 0; m_pcnt = 0;
      m_ack = 0; m_err = 0; m_out = 0; m_tick = 0;
      return;
    end
    m_err = div_req && (int'(div_val) < 2);
    m_ack = 0;
    wrap  = (old_mode != 0) && (m_phase == m_div - 1);
    if (old_pend != 0 && (old_mode == 0 || wrap)) begin
      m_div = old_pend; m_pend = 0; m_ack = 1;
    end
    if (div_req && int'(div_val) >= 2 && old_pend == 0) m_pend = int'(div_val);
    if (old_mode == 0)      begin if (en) m_mode = 1; end
    else if (old_mode == 1) begin if (!en) m_mode = 2; end
    else if (en)            m_mode = 1;
    else if (wrap)          m_mode = 0;
    if (old_mode == 0 || wrap) m_phase = 0;
    else                       m_phase = m_phase + 1;
    if (wrap) m_pcnt = (m_pcnt + 1) % 65536;
    m_out  = (m_mode != 0) && (m_phase < (m_div + 1) / 2);
    m_tick = (m_mode != 0) && (m_phase == 0);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    check("cnt",        cnt,        m_phase);
    check("clk_out",    clk_out,    m_out);
    check("active_div", active_div, m_div);
    check("div_busy",   div_busy,   m_pend != 0);
    check("div_ack",    div_ack,    m_ack);
    check("div_err",    div_err,    m_err);
`ifdef CLKDIV_TICK_EN
    check("rise_tick",  rise_tick,  m_tick);
    check("period_cnt", period_cnt, m_pcnt);
`endif
  end

  task automatic request(int v);
    div_req = 1'b1;
    div_val = 4'(v);
    @(negedge clk);
    div_req = 1'b0;
  endtask

  task automatic wait_ack(string nm);
    int k = 0;
    while (div_ack !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(nm, div_ack, 1);
  endtask

  task automatic wait_phase(int p, string nm);
    int k = 0;
    while (!(m_mode != 0 && m_phase == p) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check(nm, cnt, p);
  endtask

  logic [7:0]  pat8;
  logic [5:0]  pat6;
  logic [23:0] cnt6;

  initial begin
    reset = 1'b0; en = 1'b0; div_req = 1'b0; div_val = 4'd0;

    // Reset default and N=3 waveform
    repeat (2) @(negedge clk);
    check("rst_cnt",  cnt, 0);
    check("rst_out",  clk_out, 0);
    check("rst_div",  active_div, 3);
    check("rst_busy", div_busy, 0);
    reset = 1'b1; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat6[5-i] = clk_out;
      cnt6[23-4*i -: 4] = cnt;
    end
    check("n3_pattern", pat6, 6'b110110);
    check("n3_counts",  cnt6, 24'h012012);

    // Change mid-period to N=4
    wait_phase(0, "mid_wait");
    request(4);
    check("mid_busy", div_busy, 1);
    wait_ack("mid_ack");
    check("mid_div", active_div, 4);
    for (int i = 0; i < 8; i++) begin
      pat8[7-i] = clk_out;
      @(negedge clk);
    end
    check("n4_pattern", pat8, 8'b11001100);

    // Request on the wrap edge, then ignored and invalid requests
    wait_phase(3, "wrap_wait");
    request(5);
    check("wrap_busy", div_busy, 1);
    div_req = 1'b1; div_val = 4'd6;
    @(negedge clk);
    div_val = 4'd1;
    @(negedge clk);
    div_req = 1'b0;
    check("err_pulse", div_err, 1);
    check("err_div",   active_div, 4);
    check("late_ack0", div_ack, 0);
    @(negedge clk);
    check("late_ack1", div_ack, 0);
    @(negedge clk);
    check("wrap_ack",  div_ack, 1);
    check("wrap_div",  active_div, 5);

    // Graceful stop at N=4
    request(4);
    wait_ack("stop_setup");
    wait_phase(1, "stop_wait");
    en = 1'b0;
    @(negedge clk); check("stop_c2", cnt, 2);
    @(negedge clk); check("stop_c3", cnt, 3);
    @(negedge clk); check("stop_idle_cnt", cnt, 0);
    check("stop_idle_out", clk_out, 0);
    @(negedge clk); check("stop_hold_out", clk_out, 0);
    en = 1'b1;
    wait_phase(1, "resume_wait");
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pat6[5-i] = clk_out;
      cnt6[23-4*i -: 4] = cnt;
    end
    check("resume_out", pat6[5:3], 3'b011);
    check("resume_cnt", cnt6[23:12], 12'h301);

    // Reset mid-operation with a pending request
    request(7);
    wait_ack("n7_ack");
    request(5);
    wait_phase(4, "mrst_wait");
    check("mrst_busy_pre", div_busy, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("mrst_div",  active_div, 3);
    check("mrst_busy", div_busy, 0);
    check("mrst_out",  clk_out, 0);
    check("mrst_cnt",  cnt, 0);
    check("mrst_ack",  div_ack, 0);
    repeat (20) @(negedge clk);

`ifdef CLKDIV_TICK_EN
    // N=2 for ten periods
    en = 1'b0; reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    request(2);
    wait_ack("tick_setup");
    en = 1'b1;
    repeat (21) @(negedge clk);
    check("tick_pcnt", period_cnt, 10);
    check("tick_rise", rise_tick, 1);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 9) == 0) en = ~en;
      div_req = ($urandom_range(0, 7) == 0);
      div_val = 4'($urandom_range(0, 15));
      reset   = ($urandom_range(0, 399) != 0);
    end
    reset = 1'b1; div_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
